// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the N-master AHB round-robin arbiter.
package ahb_arb_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StGranted
   } arb_state_e;

   localparam int unsigned PRIO_RR    = 0;
   localparam int unsigned PRIO_FIXED = 1;

   // Counter/index width that never collapses to zero bits.
   function automatic int unsigned width_of(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational masked priority encoder: picks the first eligible requester,
// either lowest-index (fixed) or starting just after the last owner (round-robin).
module ahb_rr_picker #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     excl,
   input  logic [IDX_W-1:0] last,
   input  logic             fixed_mode,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   localparam logic [IDX_W:0] NW = (IDX_W + 1)'(N);

   logic [N-1:0]   cand;
   logic [IDX_W:0] pos;

   assign cand  = req & ~excl;
   assign valid = |cand;

   // Scan from the farthest candidate back to the nearest so the nearest wins.
   always_comb begin
      idx = '0;
      pos = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (fixed_mode) begin
            pos = (IDX_W + 1)'(k);
         end else begin
            pos = {1'b0, last} + (IDX_W + 1)'(k + 1);
            if (pos >= NW) begin
               pos = pos - NW;
            end
         end
         if (cand[pos[IDX_W-1:0]]) begin
            idx = pos[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// N-master AHB bus arbiter: round-robin or fixed priority, grant hold while
// hready is low, locked sequences and a fairness limit on unlocked ownership.
module ahb_rr_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS   = 4,
   parameter int unsigned SEL_W         = 2,
   parameter int unsigned PRIORITY_MODE = PRIO_RR,
   parameter int unsigned MAX_HOLD      = 8,
   localparam int unsigned IDX_W        = width_of(NUM_MASTERS)
) (
   input  logic                         hclk,
   input  logic                         hresetn,
   input  logic [NUM_MASTERS-1:0]       hreq,
   input  logic [NUM_MASTERS-1:0]       hlock,
   input  logic [NUM_MASTERS*SEL_W-1:0] sel_in,
   input  logic                         hready,
   output logic [NUM_MASTERS-1:0]       hgrant,
   output logic [IDX_W-1:0]             hmaster,
   output logic [SEL_W-1:0]             sel,
   output logic                         hmastlock
);

   localparam int unsigned      HOLD_W     = width_of(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
   localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NUM_MASTERS - 1);
   localparam logic              FIXED     = (PRIORITY_MODE == PRIO_FIXED);

   arb_state_e             state_q, state_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [SEL_W-1:0]       sel_q, sel_d;
   logic                   lock_q, lock_d;

   logic [NUM_MASTERS-1:0] excl;
   logic                   pick_valid;
   logic [IDX_W-1:0]       pick_idx;
   logic                   own_req, own_lock, hold_expired;
   logic                   take_new, go_idle;

   // The current owner is never a candidate when re-arbitrating away from it.
   assign excl         = (state_q == StGranted) ? (NUM_MASTERS'(1) << owner_q) : '0;
   assign own_req      = hreq[owner_q];
   assign own_lock     = hlock[owner_q];
   assign hold_expired = (MAX_HOLD != 0) && (hold_q >= HOLD_LAST);

   ahb_rr_picker #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_picker (
      .req        (hreq),
      .excl       (excl),
      .last       (last_q),
      .fixed_mode (FIXED),
      .valid      (pick_valid),
      .idx        (pick_idx)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      hold_d   = hold_q;
      grant_d  = grant_q;
      sel_d    = sel_q;
      lock_d   = lock_q;
      take_new = 1'b0;
      go_idle  = 1'b0;

      if (hready) begin
         unique case (state_q)
            StIdle: begin
               take_new = pick_valid;
            end
            StGranted: begin
               if (own_req && own_lock) begin
                  hold_d = '0;
               end else if (!own_req) begin
                  take_new = pick_valid;
                  go_idle  = !pick_valid;
               end else if (pick_valid && hold_expired) begin
                  take_new = 1'b1;
               end else if (hold_q != HOLD_SAT) begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
            default: begin
               go_idle = 1'b1;
            end
         endcase

         if (take_new) begin
            state_d = StGranted;
            owner_d = pick_idx;
            last_d  = pick_idx;
            hold_d  = '0;
         end else if (go_idle) begin
            state_d = StIdle;
            owner_d = '0;
            hold_d  = '0;
         end

         // Outputs are re-registered on every arbitration edge.
         if (state_d == StGranted) begin
            grant_d = NUM_MASTERS'(1) << owner_d;
            sel_d   = sel_in[owner_d*SEL_W +: SEL_W];
            lock_d  = hlock[owner_d];
         end else begin
            grant_d = '0;
            sel_d   = '0;
            lock_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q <= StIdle;
         owner_q <= '0;
         last_q  <= LAST_RST;
         hold_q  <= '0;
         grant_q <= '0;
         sel_q   <= '0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         lock_q  <= lock_d;
      end
   end

   assign hgrant    = grant_q;
   assign hmaster   = owner_q;
   assign sel       = sel_q;
   assign hmastlock = lock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Self-checking bench: three arbiter configurations share one stimulus and are
// compared against a behavioural model, plus directed vectors and corner sequences.
module tb_ahb_rr_arbiter;

   logic       hclk = 1'b0;
   logic       hresetn = 1'b0;
   logic [3:0] hreq = '0;
   logic [3:0] hlock = '0;
   logic [7:0] sel_in = '0;
   logic       hready = 1'b1;

   logic [3:0] g[3];
   logic [1:0] m[3];
   logic [1:0] s[3];
   logic       l[3];

   int n_checks = 0;
   int n_fail = 0;

   // Instance 0: RR, MAX_HOLD=8; 1: RR, MAX_HOLD=2; 2: fixed, MAX_HOLD=0.
   int cfg_mode[3] = '{0, 0, 1};
   int cfg_maxh[3] = '{8, 2, 0};

   int         m_owner[3];
   int         m_last[3];
   int         m_hold[3];
   logic [1:0] m_sel[3];
   logic       m_lock[3];

   always #5 hclk = ~hclk;

   ahb_rr_arbiter dut_def (
      .hclk(hclk), .hresetn(hresetn), .hreq(hreq), .hlock(hlock), .sel_in(sel_in),
      .hready(hready), .hgrant(g[0]), .hmaster(m[0]), .sel(s[0]), .hmastlock(l[0])
   );

   ahb_rr_arbiter #(.MAX_HOLD(2)) dut_rr2 (
      .hclk(hclk), .hresetn(hresetn), .hreq(hreq), .hlock(hlock), .sel_in(sel_in),
      .hready(hready), .hgrant(g[1]), .hmaster(m[1]), .sel(s[1]), .hmastlock(l[1])
   );

   ahb_rr_arbiter #(.PRIORITY_MODE(1), .MAX_HOLD(0)) dut_fx0 (
      .hclk(hclk), .hresetn(hresetn), .hreq(hreq), .hlock(hlock), .sel_in(sel_in),
      .hready(hready), .hgrant(g[2]), .hmaster(m[2]), .sel(s[2]), .hmastlock(l[2])
   );

   function automatic int pick(logic [3:0] req, int excl, int last, int mode);
      int i;
      pick = -1;
      for (int k = 1; k <= 4; k++) begin
         i = (mode == 1) ? k - 1 : (last + k) % 4;
         if (pick < 0 && req[i] && i != excl) pick = i;
      end
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_owner[d] = -1;
         m_last[d]  = 3;
         m_hold[d]  = 0;
         m_sel[d]   = '0;
         m_lock[d]  = 1'b0;
      end
   endtask

   task automatic model_step();
      int o, w, nxt;
      if (!hready) return;
      for (int d = 0; d < 3; d++) begin
         o   = m_owner[d];
         nxt = o;
         if (o < 0) begin
            nxt = pick(hreq, -1, m_last[d], cfg_mode[d]);
            m_hold[d] = 0;
         end else if (hreq[o] && hlock[o]) begin
            m_hold[d] = 0;
         end else if (!hreq[o]) begin
            nxt = pick(hreq, o, m_last[d], cfg_mode[d]);
            m_hold[d] = 0;
         end else begin
            w = pick(hreq, o, m_last[d], cfg_mode[d]);
            if (w >= 0 && cfg_maxh[d] != 0 && m_hold[d] >= cfg_maxh[d] - 1) begin
               nxt = w;
               m_hold[d] = 0;
            end else if (m_hold[d] < cfg_maxh[d]) begin
               m_hold[d]++;
            end
         end
         if (nxt >= 0 && nxt != o) m_last[d] = nxt;
         m_owner[d] = nxt;
         m_sel[d]   = (nxt >= 0) ? sel_in[nxt*2 +: 2] : 2'b00;
         m_lock[d]  = (nxt >= 0) ? hlock[nxt] : 1'b0;
      end
   endtask

   task automatic check_models(string tag);
      logic [8:0] act, expv;
      for (int d = 0; d < 3; d++) begin
         act  = {g[d], m[d], s[d], l[d]};
         expv = {(m_owner[d] < 0) ? 4'b0000 : (4'b0001 << m_owner[d]),
                 (m_owner[d] < 0) ? 2'd0 : 2'(m_owner[d]), m_sel[d], m_lock[d]};
         n_checks++;
         if (act !== expv) begin
            n_fail++;
            $display("FAIL %s dut%0d: got grant=%b master=%0d sel=%0d lock=%b, want grant=%b master=%0d sel=%0d lock=%b",
                     tag, d, act[8:5], act[4:3], act[2:1], act[0],
                     expv[8:5], expv[4:3], expv[2:1], expv[0]);
         end
      end
   endtask

   task automatic check_val(string tag, int actual, int want);
      n_checks++;
      if (actual != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, actual, want);
      end
   endtask

   task automatic tick(string tag);
      @(posedge hclk);
      model_step();
      #1;
      check_models(tag);
   endtask

   task automatic do_reset();
      hresetn = 1'b0;
      hreq    = '0;
      hlock   = '0;
      hready  = 1'b1;
      repeat (2) @(posedge hclk);
      #1;
      hresetn = 1'b1;
      model_reset();
      check_models("reset");
   endtask

   typedef struct {
      string      name;
      logic [3:0] req;
      logic [3:0] lock;
      logic       rdy;
      logic [3:0] grant;
      logic [1:0] master;
      logic [1:0] sel;
      logic       mlock;
   } vec_t;

   vec_t vecs[12];
   logic [1:0] rr2_own[9];

   initial begin
      // sel_in 8'h1B: master0 -> 3, master1 -> 2, master2 -> 1, master3 -> 0
      vecs[0]  = '{"req0110",     4'b0110, 4'b0000, 1'b1, 4'b0010, 2'd1, 2'd2, 1'b0};
      vecs[1]  = '{"drop1",       4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0};
      vecs[2]  = '{"lock2",       4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b1};
      vecs[3]  = '{"wait_a",      4'b0000, 4'b0000, 1'b0, 4'b0100, 2'd2, 2'd1, 1'b1};
      vecs[4]  = '{"wait_b",      4'b0000, 4'b0000, 1'b0, 4'b0100, 2'd2, 2'd1, 1'b1};
      vecs[5]  = '{"wait_c",      4'b0000, 4'b0000, 1'b0, 4'b0100, 2'd2, 2'd1, 1'b1};
      vecs[6]  = '{"ready_idle",  4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b0};
      vecs[7]  = '{"rr_after2",   4'b1001, 4'b0000, 1'b1, 4'b1000, 2'd3, 2'd0, 1'b0};
      vecs[8]  = '{"keep3",       4'b1001, 4'b0000, 1'b1, 4'b1000, 2'd3, 2'd0, 1'b0};
      vecs[9]  = '{"to0",         4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 2'd3, 1'b0};
      vecs[10] = '{"idle_again",  4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b0};
      vecs[11] = '{"rewin0",      4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 2'd3, 1'b0};
      rr2_own  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

      model_reset();
      sel_in = 8'h1B;
      do_reset();

      // Directed vectors against instance 0 (RR, MAX_HOLD=8).
      foreach (vecs[i]) begin
         hreq   = vecs[i].req;
         hlock  = vecs[i].lock;
         hready = vecs[i].rdy;
         tick(vecs[i].name);
         n_checks++;
         if ({g[0], m[0], s[0], l[0]} !== {vecs[i].grant, vecs[i].master, vecs[i].sel,
                                            vecs[i].mlock}) begin
            n_fail++;
            $display("FAIL vec %s: got grant=%b master=%0d sel=%0d lock=%b, want grant=%b master=%0d sel=%0d lock=%b",
                     vecs[i].name, g[0], m[0], s[0], l[0], vecs[i].grant, vecs[i].master,
                     vecs[i].sel, vecs[i].mlock);
         end
      end

      // Fairness rotation (MAX_HOLD=2) and fixed-priority starvation of others.
      do_reset();
      hreq = 4'b1111;
      for (int i = 0; i < 9; i++) begin
         tick("rotate");
         check_val("rr2_owner", int'(m[1]), int'(rr2_own[i]));
         check_val("fx0_owner", int'(m[2]), 0);
      end
      hreq = 4'b1110;
      tick("fx_release");
      check_val("fx0_release_grant", int'(g[2]), 2);

      // Locked sequence on master 2 is never pre-empted.
      do_reset();
      hreq  = 4'b1111;
      hlock = 4'b0100;
      repeat (5) tick("lock_lead");
      for (int i = 0; i < 10; i++) begin
         tick("locked");
         check_val("rr2_locked_owner", int'(m[1]), 2);
         check_val("rr2_locked_mastlock", int'(l[1]), 1);
      end
      hlock = 4'b0000;
      tick("unlock1");
      check_val("rr2_unlock_owner", int'(m[1]), 2);
      check_val("rr2_unlock_mastlock", int'(l[1]), 0);
      tick("unlock2");
      check_val("rr2_handover", int'(m[1]), 3);

      // Asynchronous reset mid-grant clears outputs before the next edge.
      #2;
      hresetn = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         check_val("async_rst_outputs", int'({g[d], m[d], s[d], l[d]}), 0);
      end
      @(posedge hclk);
      #1;
      hresetn = 1'b1;
      model_reset();
      hreq = 4'b1111;
      tick("post_reset");
      check_val("post_reset_rr_first", int'(g[0]), 1);

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         hreq   = 4'($urandom_range(0, 15));
         hlock  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         hready = ($urandom_range(0, 3) != 0);
         sel_in = 8'($urandom);
         tick("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_rr_arbiter.md
# ahb_rr_arbiter

Parametrised N-master AHB bus arbiter, the next-generation replacement for the two-master fixed arbiter. It sits between the masters and the address/write-data muxes, grants one requester at a time, and drives the slave-select and master-index to the muxes. Added over the previous generation: N masters, round-robin or fixed-priority mode, grant hold while HREADY is low, locked-transfer support and a fairness hold limit.

## Interface
- NUM_MASTERS, 4, number of requesting masters (2..16)
- SEL_W, 2, width of each master's slave-select field
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (master 0 highest)
- MAX_HOLD, 8, max consecutive completed transfers an unlocked owner keeps the bus while others request; 0 = unlimited
- hclk  in  1  bus clock; all state on rising edge
- hresetn  in  1  asynchronous active-low reset
- hreq  in  NUM_MASTERS  per-master bus request
- hlock  in  NUM_MASTERS  per-master locked-transfer request
- sel_in  in  NUM_MASTERS*SEL_W  concatenated slave selects, master i at [i*SEL_W +: SEL_W]
- hready  in  1  transfer-complete from the selected slave
- hgrant  out  NUM_MASTERS  one-hot grant, all zero when idle
- hmaster  out  clog2(NUM_MASTERS)  index of granted master
- sel  out  SEL_W  slave select of granted master, to address/write muxes
- hmastlock  out  1  current grant is a locked sequence

## Operation
- States: IDLE (no grant), GRANTED (one owner). Counters: hold_cnt (clog2(MAX_HOLD+1) bits, saturating); last_owner pointer.
- Arbitration happens only on a rising edge with hready=1. With hready=0 every register holds its value.
- Winner selection: fixed mode = lowest-index requester; round-robin = first requester at index last_owner+1, last_owner+2, ... wrapping modulo NUM_MASTERS.
- IDLE, hready=1: no hreq -> stay IDLE; any hreq -> GRANTED with the winner, hold_cnt=0.
- GRANTED, hready=1, owner o:
  - hreq[o]=1 and hlock[o]=1 -> keep o, hold_cnt=0 (locked sequence is never pre-empted).
  - hreq[o]=0 -> re-arbitrate among the others; none -> IDLE.
  - hreq[o]=1, another request present, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1 -> grant the winner among the others (o excluded), hold_cnt=0.
  - Otherwise keep o, hold_cnt++.
- On every new grant: last_owner <= winner. Same owner re-won after IDLE still counts as a new grant.
- sel is re-registered from the owner's sel_in slice on every arbitration edge while GRANTED; 0 in IDLE.
- hmastlock = registered hlock[owner] while GRANTED, else 0.
- A request dropped while hready=0 is honoured only at the next hready=1 edge.

## Timing
- Reset (async assert, sync-to-clock deassert handled upstream): state IDLE, hgrant=0, hmaster=0, sel=0, hmastlock=0, hold_cnt=0, last_owner=NUM_MASTERS-1 (master 0 wins first in round-robin).
- Latency: hreq sampled at edge k (hready=1) -> hgrant/hmaster/sel valid after edge k; one cycle request-to-grant.
- Handover is back-to-back: old owner's hgrant falls in the same cycle the new owner's rises; never two grants high, never a gap while any request is pending.
- Reset mid-transfer: outputs drop to reset values immediately, no completion of the current grant.
- All outputs registered; no combinational input-to-output path.

## Structure
- Package ahb_arb_pkg: state enum (IDLE, GRANTED), PRIO_RR / PRIO_FIXED constants, clog2-based width helper.
- Sub-module ahb_rr_picker: combinational masked priority encoder (requests, start pointer, exclude mask, mode -> valid, index); instantiated once.

## Test plan
- Reset then hreq=4'b0110, hready=1, RR -> next edge hgrant=4'b0010, hmaster=1, sel=sel_in[1]; drop hreq[1] -> hgrant=4'b0100, hmaster=2.
- All four request continuously, MAX_HOLD=2, RR -> ownership 0,0,1,1,2,2,3,3,0 over 8 completed transfers.
- Same stimulus, PRIORITY_MODE=1, MAX_HOLD=0 -> master 0 holds indefinitely; release hreq[0] -> master 1 granted next edge.
- Master 2 owns with hlock[2]=1 while all request, MAX_HOLD=2 -> keeps grant 10 transfers, hmastlock=1; clear hlock -> handover after 2 more transfers, hmastlock=0.
- Owner drops hreq while hready=0 for 3 cycles -> hgrant, sel, hmaster unchanged until first hready=1 edge, then IDLE (hgrant=0, sel=0) if nothing else requests.
- Assert hresetn=0 mid-grant, asynchronously -> hgrant=0, hmaster=0, sel=0, hmastlock=0 before next clock edge; after release master 0 wins first.
